// File: rtl/hs_latency_monitor.sv
// rtl/hs_latency_monitor.sv - multi-channel req/ack latency and protocol monitor
module hs_latency_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       lat_valid,
  output logic [NUM_CH*LAT_W-1:0] lat_val,
  output logic [NUM_CH-1:0]       err_early,
  output logic [NUM_CH-1:0]       err_timeout,
  output logic [NUM_CH-1:0]       err_proto,
  output logic [CNT_W-1:0]        ok_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  // Up to three error events per channel can land in one cycle.
  localparam int INC_W = $clog2(3 * NUM_CH + 1);
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [LAT_W-1:0] lc_q    [NUM_CH];
  logic [LAT_W-1:0] lc_d    [NUM_CH];
  logic [LAT_W-1:0] done_l  [NUM_CH];

  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] ack_q;
  logic [NUM_CH-1:0] rr;
  logic [NUM_CH-1:0] ar;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] ev_early;
  logic [NUM_CH-1:0] ev_tmo;
  logic [NUM_CH-1:0] ev_proto;
  logic [NUM_CH-1:0] ev_ok;
  logic [INC_W-1:0]  err_inc;
  logic [INC_W-1:0]  ok_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [INC_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(cnt) + SUM_W'(inc);
    return (s > CNT_MAX) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign rr = req & ~req_q;
  assign ar = ack & ~ack_q;

  // Per-channel handshake FSM next state, completion and error event decode.
  always_comb begin
    err_inc  = '0;
    ok_inc   = '0;
    done     = '0;
    ev_early = '0;
    ev_tmo   = '0;
    ev_proto = '0;
    ev_ok    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lc_d[i]    = lc_q[i];
      done_l[i]  = '0;
      if (!en) begin
        state_d[i] = ST_IDLE;
        lc_d[i]    = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (rr[i] && ar[i]) begin
              done[i]   = 1'b1;
              done_l[i] = '0;
            end else if (rr[i]) begin
              state_d[i] = ST_WAIT;
              lc_d[i]    = LAT_W'(1);
            end else if (ar[i]) begin
              ev_proto[i] = 1'b1;
            end
          end
          ST_WAIT: begin
            if (ar[i]) begin
              // A req re-rise coinciding with the ack rise is ignored.
              done[i]    = 1'b1;
              done_l[i]  = lc_q[i];
              state_d[i] = ST_IDLE;
              lc_d[i]    = '0;
            end else begin
              // A second req rise is flagged but does not restart timing.
              if (rr[i]) ev_proto[i] = 1'b1;
              if (lc_q[i] == MAX_L) begin
                ev_tmo[i]  = 1'b1;
                state_d[i] = ST_IDLE;
                lc_d[i]    = '0;
              end else begin
                lc_d[i] = lc_q[i] + LAT_W'(1);
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            lc_d[i]    = '0;
          end
        endcase
      end
      ev_early[i] = done[i] && (done_l[i] < MIN_L);
      ev_ok[i]    = done[i] && !ev_early[i];
      err_inc     = err_inc + INC_W'(ev_early[i]) + INC_W'(ev_tmo[i]) + INC_W'(ev_proto[i]);
      ok_inc      = ok_inc + INC_W'(ev_ok[i]);
    end
  end

  // busy comes straight from the state register.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] == ST_WAIT);
    end
  end

  // Edge-detect history, channel state and completion reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      ack_q     <= '0;
      lat_valid <= '0;
      lat_val   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        lc_q[i]    <= '0;
      end
    end else begin
      req_q     <= req;
      ack_q     <= ack;
      lat_valid <= done;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lc_q[i]    <= lc_d[i];
        if (done[i]) lat_val[i*LAT_W +: LAT_W] <= done_l[i];
      end
    end
  end

  // Sticky error flags and saturating counters; clr overrides new events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_early   <= '0;
      err_timeout <= '0;
      err_proto   <= '0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
    end else if (clr) begin
      err_early   <= '0;
      err_timeout <= '0;
      err_proto   <= '0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
    end else begin
      err_early   <= err_early | ev_early;
      err_timeout <= err_timeout | ev_tmo;
      err_proto   <= err_proto | ev_proto;
      ok_cnt      <= sat_add(ok_cnt, ok_inc);
      err_cnt     <= sat_add(err_cnt, err_inc);
    end
  end

endmodule
